// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - registered immediate generator with upper-immediate prefix capture (optional C-upper mode: IMM_EXT_UPPER_EN)
module imm_ext_pipe #(
    parameter int DATA_W       = 16,
    parameter int TB_W         = 4,
    parameter int TC_W         = 8,
    parameter int TD_W         = 12,
    parameter bit JUMP_FROM_PC = 1'b0,
    parameter logic [DATA_W-TD_W-1:0] JUMP_FILL = '1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [2:0]             mode,
    input  logic [TB_W-1:0]        tb,
    input  logic [TC_W-1:0]        tc,
    input  logic [TD_W-1:0]        td,
    input  logic [DATA_W-TD_W-1:0] pc_hi,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out,
    output logic                   prefix_pending,
    output logic                   illegal
);

    localparam logic [2:0] M_B     = 3'b000;
    localparam logic [2:0] M_C     = 3'b001;
    localparam logic [2:0] M_D     = 3'b010;
    localparam logic [2:0] M_CZ    = 3'b011;
    localparam logic [2:0] M_PFX   = 3'b100;
`ifdef IMM_EXT_UPPER_EN
    localparam logic [2:0] M_UPPER = 3'b101;
`endif

    typedef enum logic {IDLE, PFX} state_t;

    state_t              state_q, state_d;
    logic [TC_W-1:0]     prefix_q, prefix_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic                illegal_q, illegal_d;

    logic [TC_W+TB_W-1:0] comb_b;
    logic [TC_W+TC_W-1:0] comb_c;
    logic [63:0]          b_plain, b_pfx, c_plain, c_pfx, cz_plain, cz_pfx;
    logic [DATA_W-1:0]    d_val;
    logic                 pfx_active;

    // Operands are formed 64 bits wide so a prefixed field wider than DATA_W
    // simply truncates to its low DATA_W bits.
    assign pfx_active = (state_q == PFX);
    assign comb_b     = {prefix_q, tb};
    assign comb_c     = {prefix_q, tc};
    assign b_plain    = 64'(signed'(tb));
    assign b_pfx      = 64'(signed'(comb_b));
    assign c_plain    = 64'(signed'(tc));
    assign c_pfx      = 64'(signed'(comb_c));
    assign cz_plain   = 64'(tc);
    assign cz_pfx     = 64'(comb_c);
    assign d_val      = {(JUMP_FROM_PC ? pc_hi : JUMP_FILL), td};

    always_comb begin
        state_d     = state_q;
        prefix_d    = prefix_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        illegal_d   = 1'b0;
        if (stall) begin
            out_valid_d = out_valid_q;
            illegal_d   = illegal_q;
        end else if (flush) begin
            state_d  = IDLE;
            prefix_d = '0;
        end else if (in_valid) begin
            case (mode)
                M_B, M_C, M_CZ, M_D: begin
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                    prefix_d    = '0;
                    case (mode)
                        M_B:     out_d = pfx_active ? b_pfx[DATA_W-1:0]  : b_plain[DATA_W-1:0];
                        M_C:     out_d = pfx_active ? c_pfx[DATA_W-1:0]  : c_plain[DATA_W-1:0];
                        M_CZ:    out_d = pfx_active ? cz_pfx[DATA_W-1:0] : cz_plain[DATA_W-1:0];
                        default: out_d = d_val;
                    endcase
                end
                M_PFX: begin
                    state_d  = PFX;
                    prefix_d = tc;
                end
`ifdef IMM_EXT_UPPER_EN
                M_UPPER: begin
                    out_valid_d = 1'b1;
                    out_d       = cz_plain[DATA_W-1:0] << (DATA_W - TC_W);
                    state_d     = IDLE;
                    prefix_d    = '0;
                end
`endif
                default: begin
                    out_d     = '0;
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prefix_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prefix_q    <= prefix_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
        end
    end

    assign out            = out_q;
    assign out_valid      = out_valid_q;
    assign illegal        = illegal_q;
    assign prefix_pending = pfx_active;

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Registered, parametrised immediate-generation stage for the 16-bit core's decode path.
- Produces the sign-extended, zero-extended or jump-target operand for B (AOI), C (branch) and D (jump) instruction types.
- Adds a PREFIX mode: an 8-bit upper-immediate prefix instruction is captured and concatenated with the next instruction's immediate field.
- Sits between the decoder and the operand mux; one-cycle latency; honours pipeline stall and flush.

Parameters:
- DATA_W, 16, output operand width.
- TB_W, 4, type-B field width.
- TC_W, 8, type-C field width; also the prefix payload width.
- TD_W, 12, type-D field width; must be < DATA_W.
- JUMP_FROM_PC, 0, 1 = jump upper bits taken from pc_hi; 0 = taken from JUMP_FILL.
- JUMP_FILL, all ones (DATA_W-TD_W bits), constant upper bits for jumps when JUMP_FROM_PC=0.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  decode slot holds an instruction.
- stall  in  1  hold stage; inputs ignored, state and outputs frozen.
- flush  in  1  discard pending prefix and output.
- mode  in  3  000 B-sext, 001 C-sext, 010 D-jump, 011 C-zext, 100 PREFIX, 101 C-upper (optional), 110/111 illegal.
- tb  in  TB_W  type-B field.
- tc  in  TC_W  type-C field / prefix payload.
- td  in  TD_W  type-D field.
- pc_hi  in  DATA_W-TD_W  upper PC bits of the current instruction.
- out_valid  out  1  out is valid this cycle.
- out  out  DATA_W  generated operand.
- prefix_pending  out  1  a prefix is held (state PFX).
- illegal  out  1  one-cycle pulse on an illegal mode.

Behaviour:
- Reset (async, rst=1): state=IDLE, prefix reg=0, out=0, out_valid=0, prefix_pending=0, illegal=0.
- All outputs are registered. An accepted input (in_valid & ~stall & ~flush) at edge N drives out/out_valid/illegal after edge N.
- Cycles with no acceptance: out_valid=0, illegal=0, out holds its last value.
- stall=1: state, prefix, out, out_valid and illegal all hold; no acceptance.
- Field value F, no prefix:
  - B: sign-extend tb to DATA_W.
  - C: sign-extend tc.
  - C-zext: zero-extend tc.
  - D: {upper, td}, where upper = pc_hi if JUMP_FROM_PC, else JUMP_FILL.
- States:
  - IDLE, accept PREFIX: prefix reg=tc; go to PFX; out_valid=0 (a prefix produces no operand).
  - PFX, accept B/C/C-zext: combined = {prefix, field}. B and C sign-extend combined from its MSB; C-zext zero-extends it. If combined is wider than DATA_W, keep the low DATA_W bits. out_valid=1; return to IDLE.
  - PFX, accept D: prefix is ignored and consumed; normal D result; return to IDLE.
  - PFX, accept PREFIX: prefix reg overwritten with the new tc; stay in PFX (last prefix wins, no chaining).
  - Any state, accept illegal mode: out=0, out_valid=0, illegal=1 for one cycle; state and prefix unchanged.
- flush=1 (not stalled): state=IDLE, prefix reg=0, out_valid=0, illegal=0; the same-cycle input is dropped. flush has priority over in_valid.
- stall and flush together: stall wins; flush is not taken.
- Reset mid-PFX clears the prefix immediately (asynchronous).
- Examples (default parameters):
  - B tb=0x8 → 0xFFF8.
  - PFX 0x12 then C tc=0x34 → 0x1234.
  - PFX 0x12 then B tb=0x5 → combined 0x125 → 0x0125.
  - PFX 0x82 then B tb=0x5 → 0xF825.

Optional Feature:
- Macro IMM_EXT_UPPER_EN.
- Defined: mode 101 (C-upper) outputs tc << (DATA_W-TC_W), low bits 0 (tc=0xAB → 0xAB00). Ignores and consumes a pending prefix; returns to IDLE.
- Undefined: mode 101 is treated as illegal (illegal pulse, out=0, state unchanged).

Test Plan:
- Reset, then B tb=0x7 → next cycle out=0x0007, out_valid=1; then B tb=0x8 → 0xFFF8.
- C-zext tc=0x80 → 0x0080. C tc=0x80 → 0xFF80. D td=0x123 with JUMP_FROM_PC=0 → 0xF123; rerun with JUMP_FROM_PC=1, pc_hi=0x4 → 0x4123.
- PREFIX 0x12 → out_valid=0, prefix_pending=1. Then C tc=0x34 → 0x1234, prefix_pending=0. Back-to-back PREFIX 0x11 then PREFIX 0x22, then C 0x00 → 0x2200.
- PREFIX 0x12 with stall=1 for 3 cycles → no capture, prefix_pending stays 0. Prefix accepted, then flush=1 → prefix_pending=0; next C tc=0x34 → 0x0034.
- Mode 110 → illegal=1 for one cycle, out_valid=0. Mode 101 → 0xAB00 for tc=0xAB with IMM_EXT_UPPER_EN, illegal pulse without it.
- rst asserted while in PFX (between clock edges) → prefix_pending=0 and out_valid=0 immediately, before the next clk edge.
